// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the round-robin UART TX arbiter and the transmitter.
// master: arbiter side; slave: requesters plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_send;
    logic [7:0]           tx_data;
    logic                 tx_active_flag;
    logic                 tx_done_flag;
    logic [IDX_W-1:0]     grant_id;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  req_valid, req_data, tx_active_flag, tx_done_flag,
        output req_ready, tx_send, tx_data, grant_id, busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_active_flag, tx_done_flag,
        input  req_ready, tx_send, tx_data, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional transmitter watchdog enabled by defining TX_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACTIVE, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    logic [31:0]      cand;
    logic             win_found;
    logic             accept;
    logic [7:0]       win_data;
    logic             tx_send_q;
    logic [7:0]       tx_data_q;
    logic [IDX_W-1:0] grant_id_q;
    logic             busy_q;
    logic             in_wait;

    assign in_wait = (state_q == WAIT_ACTIVE) || (state_q == WAIT_DONE);

`ifdef TX_TIMEOUT_EN
    logic [31:0] wd_cnt_q;
    logic        timeout_err_q;
    logic        wd_expire;

    assign wd_expire = in_wait && ((wd_cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

    // Watchdog counts cycles spent waiting on the transmitter for the current byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (accept) begin
                wd_cnt_q <= '0;
            end else if (in_wait) begin
                wd_cnt_q <= wd_cnt_q + 32'd1;
            end
            if (wd_expire) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout  = 32'(TIMEOUT_CYCLES);
    assign bus.timeout_err = 1'b0;
`endif

    // First valid requester after the previous winner, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand     = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && bus.req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_data      = 8'(bus.req_data >> {win_idx, 3'b000});
    assign bus.req_ready = (state_q == IDLE && win_found) ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND:        state_d = WAIT_ACTIVE;
            WAIT_ACTIVE: if (bus.tx_active_flag) state_d = WAIT_DONE;
            WAIT_DONE:   if (bus.tx_done_flag) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
`ifdef TX_TIMEOUT_EN
        if (wd_expire) begin
            state_d = IDLE;
        end
`endif
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            tx_send_q  <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_send_q <= (state_d == SEND);
            busy_q    <= (state_d != IDLE);
            if (accept) begin
                tx_data_q  <= win_data;
                grant_id_q <= win_idx;
                rr_ptr_q   <= win_idx;
            end
        end
    end

    assign bus.tx_send  = tx_send_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;
endmodule
